// File: rtl/common_pkg.sv
// Shared CBus request/response bundles and arbitration types.
// Imported by every block that talks to the CBus.
package common;

    typedef enum logic {
        ARB_FIXED,
        ARB_ROUND_ROBIN
    } arb_policy_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ARM,
        ARB_LOCKED
    } arb_state_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational N-way picker: first valid index scanning upward from ptr
// with wrap-around, or lowest valid index under fixed priority.
module rr_priority_picker
    import common::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    input  arb_policy_t      policy,
    output logic [IDX_W-1:0] sel,
    output logic             any
);

    int base;
    int pos;

    always_comb begin
        sel  = '0;
        any  = 1'b0;
        base = 0;
        pos  = 0;
        if (policy == ARB_ROUND_ROBIN && int'(ptr) < N) begin
            base = int'(ptr);
        end
        for (int i = 0; i < N; i++) begin
            pos = base + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!any && valid[pos]) begin
                any = 1'b1;
                sel = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-to-1 CBus arbiter: picks one master, locks the grant until the slave
// signals last, optionally registering the grant for timing relief.
module cbus_rr_arbiter
    import common::*;
#(
    parameter int          NUM_INPUTS       = 2,
    parameter arb_policy_t POLICY           = ARB_ROUND_ROBIN,
    parameter bit          REGISTERED_GRANT = 1'b0,
    localparam int         IDX_W = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  cbus_req_t  [NUM_INPUTS-1:0]       ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0]       iresps,
    output cbus_req_t                         oreq,
    input  cbus_resp_t                        oresp,
    output logic       [NUM_INPUTS-1:0]       grant,
    output logic                              busy
);

    arb_state_t       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] ptr;

    logic [NUM_INPUTS-1:0] valids;
    logic [IDX_W-1:0]      sel;
    logic                  any;
    logic [IDX_W-1:0]      owner;
    logic                  active;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
        if (POLICY != ARB_ROUND_ROBIN || int'(i) >= NUM_INPUTS - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    always_comb begin
        valids = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            valids[i] = ireqs[i].valid;
        end
    end

    rr_priority_picker #(
        .N     (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid  (valids),
        .ptr    (ptr),
        .policy (POLICY),
        .sel    (sel),
        .any    (any)
    );

    // Zero-latency mode forwards the picker winner while still IDLE.
    always_comb begin
        owner  = idx;
        active = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (!REGISTERED_GRANT && any) begin
                    owner  = sel;
                    active = 1'b1;
                end
            end
            ARB_ARM, ARB_LOCKED: begin
                active = 1'b1;
            end
            default: begin
                active = 1'b0;
            end
        endcase
    end

    always_comb begin
        oreq   = '0;
        iresps = '0;
        grant  = '0;
        if (resetn && active) begin
            oreq          = ireqs[owner];
            iresps[owner] = oresp;
            grant[owner]  = 1'b1;
        end
    end

    assign busy = resetn && (state != ARB_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ARB_IDLE;
            idx   <= '0;
            ptr   <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (any) begin
                        if (REGISTERED_GRANT) begin
                            idx   <= sel;
                            state <= ARB_ARM;
                        end else if (oresp.last) begin
                            ptr <= next_ptr(sel);
                        end else begin
                            idx   <= sel;
                            state <= ARB_LOCKED;
                        end
                    end
                end
                ARB_ARM, ARB_LOCKED: begin
                    if (oresp.last) begin
                        state <= ARB_IDLE;
                        ptr   <= next_ptr(idx);
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Self-checking bench: round-robin, fixed and registered-grant instances
// with a grant-order scoreboard popped on each completing beat.
module tb_cbus_rr_arbiter;
    import common::*;

    logic clk;
    int   checks;
    int   errs;

    cbus_req_t  [3:0] rq4;
    cbus_resp_t [3:0] rs4;
    cbus_req_t        oq4;
    cbus_resp_t       os4;
    logic       [3:0] g4;
    logic             b4;
    logic             rn4;

    cbus_req_t  [2:0] rq3;
    cbus_resp_t [2:0] rs3;
    cbus_req_t        oq3;
    cbus_resp_t       os3;
    logic       [2:0] g3;
    logic             b3;
    logic             rn3;

    cbus_req_t  [1:0] rq2;
    cbus_resp_t [1:0] rs2;
    cbus_req_t        oq2;
    cbus_resp_t       os2;
    logic       [1:0] g2;
    logic             b2;
    logic             rn2;

    int q4[$];
    int q3[$];

    cbus_rr_arbiter #(
        .NUM_INPUTS       (4),
        .POLICY           (ARB_ROUND_ROBIN),
        .REGISTERED_GRANT (1'b0)
    ) u_rr (
        .clk    (clk),
        .resetn (rn4),
        .ireqs  (rq4),
        .iresps (rs4),
        .oreq   (oq4),
        .oresp  (os4),
        .grant  (g4),
        .busy   (b4)
    );

    cbus_rr_arbiter #(
        .NUM_INPUTS       (3),
        .POLICY           (ARB_FIXED),
        .REGISTERED_GRANT (1'b0)
    ) u_fx (
        .clk    (clk),
        .resetn (rn3),
        .ireqs  (rq3),
        .iresps (rs3),
        .oreq   (oq3),
        .oresp  (os3),
        .grant  (g3),
        .busy   (b3)
    );

    cbus_rr_arbiter #(
        .NUM_INPUTS       (2),
        .POLICY           (ARB_ROUND_ROBIN),
        .REGISTERED_GRANT (1'b1)
    ) u_rg (
        .clk    (clk),
        .resetn (rn2),
        .ireqs  (rq2),
        .iresps (rs2),
        .oreq   (oq2),
        .oresp  (os2),
        .grant  (g2),
        .busy   (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic cbus_req_t mk(input int id);
        cbus_req_t r;
        r        = '0;
        r.valid  = 1'b1;
        r.size   = 2'd2;
        r.addr   = 32'h1000_0000 + 32'(id) * 32'h100;
        r.strobe = 4'hf;
        r.data   = 32'hA5A5_0000 + 32'(id);
        r.len    = 4'd3;
        return r;
    endfunction

    function automatic cbus_resp_t rsp(input logic rdy, input logic lst,
                                       input int d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = 32'(d);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    always @(negedge clk) begin : mon4
        int e;
        if (rn4 && os4.last && g4 != '0) begin
            chk("q4_nonempty", 128'(q4.size() != 0), 128'(1));
            if (q4.size() != 0) begin
                e = q4.pop_front();
                chk("q4_grant", 128'(g4), 128'(4'b0001 << e));
            end
        end
    end

    always @(negedge clk) begin : mon3
        int e;
        if (rn3 && os3.last && g3 != '0) begin
            chk("q3_nonempty", 128'(q3.size() != 0), 128'(1));
            if (q3.size() != 0) begin
                e = q3.pop_front();
                chk("q3_grant", 128'(g3), 128'(3'b001 << e));
            end
        end
    end

    initial begin
        checks = 0;
        errs   = 0;
        rn4 = 1'b0; rn3 = 1'b0; rn2 = 1'b0;
        rq4 = '0; rq3 = '0; rq2 = '0;
        os4 = '0; os3 = '0; os2 = '0;
        step();
        step();
        rn4 = 1'b1; rn3 = 1'b1; rn2 = 1'b1;
        smp();
        chk("rst_busy", 128'(b4), 128'(0));
        chk("rst_grant", 128'(g4), 128'(0));
        chk("rst_oreq", 128'(oq4), 128'(0));

        // 4-beat burst on master 0, zero latency
        step();
        rq4[0] = mk(0);
        os4 = rsp(1'b1, 1'b0, 32'h11);
        q4.push_back(0);
        smp();
        chk("t1_grant_c0", 128'(g4), 128'(4'b0001));
        chk("t1_oreq_c0", 128'(oq4), 128'(mk(0)));
        chk("t1_resp0", 128'(rs4[0]), 128'(rsp(1'b1, 1'b0, 32'h11)));
        chk("t1_resp1", 128'(rs4[1]), 128'(0));
        chk("t1_busy_c0", 128'(b4), 128'(0));
        for (int k = 1; k < 4; k++) begin
            step();
            os4 = rsp(1'b1, k == 3, 32'h11 + k);
            smp();
            chk("t1_busy", 128'(b4), 128'(1));
            chk("t1_oreq", 128'(oq4), 128'(mk(0)));
            chk("t1_resp1_idle", 128'(rs4[1]), 128'(0));
        end
        step();
        rq4[0] = '0;
        os4 = '0;
        smp();
        chk("t1_busy_end", 128'(b4), 128'(0));
        chk("t1_grant_end", 128'(g4), 128'(0));

        // fresh pointer, three masters, single-beat back-to-back
        rn4 = 1'b0;
        step();
        rn4 = 1'b1;
        step();
        rq4[0] = mk(0);
        rq4[1] = mk(1);
        rq4[2] = mk(2);
        os4 = rsp(1'b1, 1'b1, 32'h22);
        for (int k = 0; k < 6; k++) q4.push_back(k % 3);
        for (int k = 0; k < 6; k++) begin
            smp();
            chk("t2_no_lock", 128'(b4), 128'(0));
            if (k < 5) step();
        end
        step();
        rq4 = '0;
        os4 = '0;

        // master 1 locked, master 0 raises mid-burst (ptr=3 here)
        step();
        rq4[1] = mk(1);
        os4 = rsp(1'b1, 1'b0, 32'h33);
        q4.push_back(1);
        smp();
        chk("t5_grant1", 128'(g4), 128'(4'b0010));
        step();
        rq4[0] = mk(0);
        q4.push_back(0);
        smp();
        chk("t5_no_preempt", 128'(g4), 128'(4'b0010));
        chk("t5_oreq", 128'(oq4), 128'(mk(1)));
        chk("t5_resp0", 128'(rs4[0]), 128'(0));
        step();
        os4 = rsp(1'b1, 1'b1, 32'h34);
        smp();
        step();
        rq4[1] = '0;
        os4 = rsp(1'b1, 1'b0, 32'h35);
        smp();
        chk("t5_next_grant", 128'(g4), 128'(4'b0001));
        chk("t5_next_busy", 128'(b4), 128'(0));
        step();
        os4 = rsp(1'b1, 1'b1, 32'h36);
        smp();
        step();
        rq4 = '0;
        os4 = '0;

        // reset in beat 2 of a burst on master 3 (ptr=1 here)
        step();
        rq4[3] = mk(3);
        os4 = rsp(1'b1, 1'b0, 32'h44);
        smp();
        chk("t6_grant3", 128'(g4), 128'(4'b1000));
        step();
        rn4 = 1'b0;
        rq4[0] = mk(0);
        #1;
        chk("t6_rst_busy", 128'(b4), 128'(0));
        chk("t6_rst_grant", 128'(g4), 128'(0));
        chk("t6_rst_oreq", 128'(oq4), 128'(0));
        chk("t6_rst_resp3", 128'(rs4[3]), 128'(0));
        smp();
        rn4 = 1'b1;
        q4.push_back(0);
        #1;
        chk("t6_ptr0_win", 128'(g4), 128'(4'b0001));
        step();
        rq4[3] = '0;
        smp();
        chk("t6_locked_busy", 128'(b4), 128'(1));
        chk("t6_locked_grant", 128'(g4), 128'(4'b0001));
        step();
        os4 = rsp(1'b1, 1'b1, 32'h45);
        smp();
        step();
        rq4 = '0;
        os4 = '0;

        // fixed priority: 0 beats 2 until 0 drops
        rq3[0] = mk(0);
        rq3[2] = mk(2);
        os3 = rsp(1'b1, 1'b1, 32'h55);
        for (int k = 0; k < 3; k++) q3.push_back(0);
        smp();
        step();
        smp();
        step();
        smp();
        step();
        rq3[0] = '0;
        q3.push_back(2);
        smp();
        step();
        rq3 = '0;
        os3 = '0;
        step();
        rq3[2] = mk(2);
        os3 = rsp(1'b1, 1'b0, 32'h56);
        q3.push_back(2);
        smp();
        chk("fx_grant2", 128'(g3), 128'(3'b100));
        step();
        rq3[0] = mk(0);
        smp();
        chk("fx_lock_hold", 128'(g3), 128'(3'b100));
        chk("fx_lock_busy", 128'(b3), 128'(1));
        step();
        os3 = rsp(1'b1, 1'b1, 32'h57);
        smp();
        step();
        rq3 = '0;
        os3 = '0;
        smp();
        chk("fx_idle", 128'(g3), 128'(0));

        // registered grant: one added cycle
        step();
        rq2[1] = mk(1);
        os2 = rsp(1'b1, 1'b0, 32'h66);
        smp();
        chk("rg_c0_valid", 128'(oq2.valid), 128'(0));
        chk("rg_c0_grant", 128'(g2), 128'(0));
        chk("rg_c0_busy", 128'(b2), 128'(0));
        step();
        smp();
        chk("rg_c1_oreq", 128'(oq2), 128'(mk(1)));
        chk("rg_c1_grant", 128'(g2), 128'(2'b10));
        chk("rg_c1_busy", 128'(b2), 128'(1));
        chk("rg_c1_resp1", 128'(rs2[1]), 128'(rsp(1'b1, 1'b0, 32'h66)));
        chk("rg_c1_resp0", 128'(rs2[0]), 128'(0));
        step();
        smp();
        step();
        os2 = rsp(1'b1, 1'b1, 32'h67);
        smp();
        chk("rg_c3_grant", 128'(g2), 128'(2'b10));
        step();
        rq2 = '0;
        os2 = '0;
        smp();
        chk("rg_c4_busy", 128'(b2), 128'(0));
        chk("rg_c4_grant", 128'(g2), 128'(0));

        chk("q4_drain", 128'(q4.size()), 128'(0));
        chk("q3_drain", 128'(q3.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
